// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: time-setting controller for the HH-MM-SS display clock.
// Debounces the mode and increment keys, runs the RUN/SET_H/SET_M/SET_S
// mode FSM, edits the BCD time fields, drives the per-digit blink mask and
// issues a one-cycle load of the edited time into the time counter.
//
// Optional feature macro: SET_TIMEOUT_EN (edit inactivity timeout back to RUN).
//
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   key_mode, key_inc     raw active-low keys, asynchronous to clk
//   cur_hour/min/sec      live BCD time from the counter
//   set_hour/min/sec      edited BCD time
//   load                  one-cycle pulse, counter takes set_* this cycle
//   hold                  counter must not advance while high
//   blink_mask            per-display-position blank request
//   mode_state            0 RUN, 1 SET_H, 2 SET_M, 3 SET_S
//
// state | meaning
// RUN   | normal timekeeping, keys other than mode ignored
// SET_H | editing hours
// SET_M | editing minutes
// SET_S | editing seconds, next mode press loads the counter
module clock_set_ctrl #(
  parameter int DB_CYCLES      = 1000000,
  parameter int BLINK_CYCLES   = 20000000,
  parameter int TIMEOUT_CYCLES = 400000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [7:0] cur_hour,
  input  logic [7:0] cur_min,
  input  logic [7:0] cur_sec,
  output logic [7:0] set_hour,
  output logic [7:0] set_min,
  output logic [7:0] set_sec,
  output logic       load,
  output logic       hold,
  output logic [7:0] blink_mask,
  output logic [1:0] mode_state
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

  localparam int DB_W = $clog2(DB_CYCLES);
  localparam int BL_W = $clog2(BLINK_CYCLES);

  // Key path, bit 0 = mode, bit 1 = inc. Levels are active-low, 1 = released.
  logic [1:0]      key_raw, sync1, sync2, db_lvl, db_prev, press;
  logic [DB_W-1:0] db_cnt [2];

  assign key_raw = {key_inc, key_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      db_lvl  <= 2'b11;
      db_prev <= 2'b11;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= key_raw;
      sync2   <= sync1;
      db_prev <= db_lvl;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db_lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          db_lvl[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Press = falling edge of the debounced level; release produces nothing.
  assign press = db_prev & ~db_lvl;

  logic mode_ev, inc_ev;
  assign mode_ev = press[0];
  assign inc_ev  = press[1];

  // BCD field step with wrap at lim; illegal captured values restart at 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    if (v >= lim || v[3:0] > 4'd9) return 8'h00;
    else if (v[3:0] == 4'd9)       return {v[7:4] + 4'd1, 4'd0};
    else                           return {v[7:4], v[3:0] + 4'd1};
  endfunction

  state_t          state, state_nxt;
  logic [7:0]      hour_nxt, min_nxt, sec_nxt;
  logic            load_nxt;
  logic [BL_W-1:0] blink_cnt, blink_nxt;
  logic            phase, phase_nxt;

`ifdef SET_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] to_cnt, to_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      set_hour  <= 8'h12;
      set_min   <= 8'h00;
      set_sec   <= 8'h00;
      load      <= 1'b0;
      blink_cnt <= '0;
      phase     <= 1'b0;
`ifdef SET_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      state     <= state_nxt;
      set_hour  <= hour_nxt;
      set_min   <= min_nxt;
      set_sec   <= sec_nxt;
      load      <= load_nxt;
      blink_cnt <= blink_nxt;
      phase     <= phase_nxt;
`ifdef SET_TIMEOUT_EN
      to_cnt    <= to_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state;
    hour_nxt  = set_hour;
    min_nxt   = set_min;
    sec_nxt   = set_sec;
    load_nxt  = 1'b0;
    blink_nxt = blink_cnt + BL_W'(1);
    phase_nxt = phase;

    // Mode is checked first so a simultaneous inc is discarded.
    case (state)
      RUN: begin
        if (mode_ev) begin
          state_nxt = SET_H;
          hour_nxt  = cur_hour;
          min_nxt   = cur_min;
          sec_nxt   = cur_sec;
        end
      end
      SET_H: begin
        if (mode_ev)     state_nxt = SET_M;
        else if (inc_ev) hour_nxt  = bcd_inc(set_hour, 8'h23);
      end
      SET_M: begin
        if (mode_ev)     state_nxt = SET_S;
        else if (inc_ev) min_nxt   = bcd_inc(set_min, 8'h59);
      end
      SET_S: begin
        if (mode_ev) begin
          state_nxt = RUN;
          load_nxt  = 1'b1;
        end else if (inc_ev) begin
          sec_nxt = bcd_inc(set_sec, 8'h59);
        end
      end
      default: state_nxt = RUN;
    endcase

`ifdef SET_TIMEOUT_EN
    to_nxt = '0;
    if (state != RUN && !mode_ev && !inc_ev) begin
      if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) state_nxt = RUN;
      else                                     to_nxt    = to_cnt + TO_W'(1);
    end
`endif

    // Restart blinking on entry to an edit state so the field shows first.
    if (state_nxt != state && state_nxt != RUN) begin
      blink_nxt = '0;
      phase_nxt = 1'b0;
    end else if (blink_cnt == BL_W'(BLINK_CYCLES - 1)) begin
      blink_nxt = '0;
      phase_nxt = ~phase;
    end
  end

  assign mode_state = state;
  assign hold       = (state != RUN) | load;

  always_comb begin
    blink_mask = 8'h00;
    if (phase) begin
      case (state)
        SET_H:   blink_mask = 8'b1100_0000;
        SET_M:   blink_mask = 8'b0001_1000;
        SET_S:   blink_mask = 8'b0000_0011;
        default: blink_mask = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_set_ctrl.sv
module tb_clock_set_ctrl;
  localparam int DB = 4;
  localparam int BL = 8;
  localparam int TO = 64;

  logic       clk, rst, key_mode, key_inc;
  logic [7:0] cur_hour, cur_min, cur_sec;
  logic [7:0] set_hour, set_min, set_sec, blink_mask;
  logic       load, hold;
  logic [1:0] mode_state;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  int exp_loads = 0;

  // Reference model: mode index (spec encoding), edited fields as BCD.
  logic [1:0] mstate;
  logic [7:0] mh, mm, ms;

  clock_set_ctrl #(.DB_CYCLES(DB), .BLINK_CYCLES(BL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .load(load), .hold(hold), .blink_mask(blink_mask), .mode_state(mode_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Decimal model of the BCD step: illegal or out-of-range values give 00.
  function automatic logic [7:0] ref_inc(input logic [7:0] v, input int lim);
    int t, o, val;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    val = t * 10 + o;
    if (o > 9 || val > lim) return 8'h00;
    val = (val + 1) % (lim + 1);
    return {4'(val / 10), 4'(val % 10)};
  endfunction

  task automatic model_reset();
    mstate = 2'd0; mh = 8'h12; mm = 8'h00; ms = 8'h00;
  endtask

  task automatic model_apply(input bit m, input bit i);
    if (m) begin
      if (mstate == 2'd0) begin mh = cur_hour; mm = cur_min; ms = cur_sec; end
      if (mstate == 2'd3) exp_loads++;
      mstate = mstate + 2'd1;
    end else if (i) begin
      if (mstate == 2'd1) mh = ref_inc(mh, 23);
      if (mstate == 2'd2) mm = ref_inc(mm, 59);
      if (mstate == 2'd3) ms = ref_inc(ms, 59);
    end
  endtask

  task automatic press(input bit m, input bit i);
    model_apply(m, i);
    @(posedge clk); #1;
    if (m) key_mode = 1'b0;
    if (i) key_inc = 1'b0;
    repeat (DB + 6) @(posedge clk);
    #1 key_mode = 1'b1; key_inc = 1'b1;
    repeat (DB + 6) @(posedge clk);
  endtask

  task automatic goto_run();
    for (int n = 0; n < 4 && mstate != 2'd0; n++) press(1'b1, 1'b0);
  endtask

  // Bounce key_inc for 10 cycles, hold low 20, release; report field changes
  // and the delay of the first change relative to the final falling edge.
  task automatic bounce_inc(output int changes, output int first);
    logic [25:0] prev;
    changes = 0; first = -1;
    prev = {mode_state, set_hour, set_min, set_sec};
    for (int c = 0; c < 42; c++) begin
      @(posedge clk); #1;
      if (c < 10) key_inc = c[0];
      else        key_inc = (c < 30) ? 1'b0 : 1'b1;
      @(negedge clk);
      if ({mode_state, set_hour, set_min, set_sec} !== prev) begin
        changes++;
        if (first < 0) first = c - 10;
        prev = {mode_state, set_hour, set_min, set_sec};
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; key_mode = 1'b1; key_inc = 1'b1;
    cur_hour = 8'h00; cur_min = 8'h00; cur_sec = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode_state, set_hour, set_min, set_sec, load, hold, blink_mask} !== {2'd0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_values got st=%0d %h:%h:%h load=%b hold=%b mask=%h exp st=0 12:00:00 load=0 hold=0 mask=00",
               mode_state, set_hour, set_min, set_sec, load, hold, blink_mask);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_bounce();
    int ch, first;
    cur_hour = 8'h07; cur_min = 8'h31; cur_sec = 8'h15;
    bounce_inc(ch, first);
    checks++;
    if (ch != 0 || {mode_state, set_hour, set_min, set_sec} !== {mstate, mh, mm, ms}) begin
      errors++;
      $display("FAIL bounce_run changes=%0d st=%0d %h:%h:%h exp changes=0 st=%0d %h:%h:%h",
               ch, mode_state, set_hour, set_min, set_sec, mstate, mh, mm, ms);
    end
    press(1'b1, 1'b0);
    model_apply(1'b0, 1'b1);
    bounce_inc(ch, first);
    checks++;
    if (ch != 1 || set_hour !== mh) begin
      errors++;
      $display("FAIL bounce_once changes=%0d hour=%h exp changes=1 hour=%h", ch, set_hour, mh);
    end
    checks++;
    if (first < 2 + DB || first > 4 + DB) begin
      errors++;
      $display("FAIL bounce_latency got %0d cycles exp %0d..%0d", first, 2 + DB, 4 + DB);
    end
    goto_run();
    checks++;
    if (load_cnt != exp_loads) begin
      errors++;
      $display("FAIL bounce_loads got %0d exp %0d", load_cnt, exp_loads);
    end
  endtask

  task automatic test_edit_sequence();
    bit found;
    cur_hour = 8'h23; cur_min = 8'h59; cur_sec = 8'h58;
    press(1'b1, 1'b0);
    @(negedge clk);
    checks++;
    if ({mode_state, set_hour, set_min, set_sec, hold} !== {2'd1, 8'h23, 8'h59, 8'h58, 1'b1}) begin
      errors++;
      $display("FAIL edit_capture got st=%0d %h:%h:%h hold=%b exp st=1 23:59:58 hold=1",
               mode_state, set_hour, set_min, set_sec, hold);
    end
    press(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if (set_hour !== 8'h00) begin errors++; $display("FAIL edit_hour_wrap got %h exp 00", set_hour); end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({mode_state, set_min} !== {2'd2, 8'h00}) begin
      errors++; $display("FAIL edit_min_wrap got st=%0d min=%h exp st=2 min=00", mode_state, set_min);
    end
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    @(negedge clk);
    checks++;
    if ({mode_state, set_sec} !== {2'd3, 8'h59}) begin
      errors++; $display("FAIL edit_sec_step got st=%0d sec=%h exp st=3 sec=59", mode_state, set_sec);
    end
    model_apply(1'b1, 1'b0);
    @(posedge clk); #1 key_mode = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (load === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL edit_load_timeout got no load exp load within 30 cycles");
    end else if ({mode_state, set_hour, set_min, set_sec, hold} !== {2'd0, 8'h00, 8'h00, 8'h59, 1'b1}) begin
      errors++;
      $display("FAIL edit_load_cycle got st=%0d %h:%h:%h hold=%b exp st=0 00:00:59 hold=1",
               mode_state, set_hour, set_min, set_sec, hold);
    end
    @(negedge clk);
    checks++;
    if ({load, hold} !== 2'b00) begin
      errors++; $display("FAIL edit_after_load got load=%b hold=%b exp 0 0", load, hold);
    end
    @(posedge clk); #1 key_mode = 1'b1;
    repeat (DB + 6) @(posedge clk);
  endtask

  task automatic test_blink();
    bit found;
    logic [7:0] exp_mask;
    goto_run();
    press(1'b1, 1'b0);
    model_apply(1'b1, 1'b0);
    @(posedge clk); #1 key_mode = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (mode_state === 2'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL blink_entry_timeout got st=%0d exp st=2", mode_state);
    end else begin
      for (int j = 0; j < 32; j++) begin
        if (j > 0) @(negedge clk);
        exp_mask = ((j / BL) % 2 == 1) ? 8'h18 : 8'h00;
        checks++;
        if (blink_mask !== exp_mask) begin
          errors++; $display("FAIL blink_mask[%0d] got %h exp %h", j, blink_mask, exp_mask);
        end
      end
    end
    @(posedge clk); #1 key_mode = 1'b1;
    repeat (DB + 6) @(posedge clk);
  endtask

  task automatic test_same_cycle();
    goto_run();
    cur_hour = 8'h09; cur_min = 8'h45; cur_sec = 8'h30;
    press(1'b1, 1'b0);
    press(1'b1, 1'b1);
    @(negedge clk);
    checks++;
    if ({mode_state, set_hour} !== {2'd2, 8'h09} || {mode_state, set_hour} !== {mstate, mh}) begin
      errors++;
      $display("FAIL same_cycle got st=%0d hour=%h exp st=2 hour=09", mode_state, set_hour);
    end
  endtask

  task automatic test_reset_mid_edit();
    int l;
    goto_run();
    cur_hour = 8'h18; cur_min = 8'h22; cur_sec = 8'h41;
    press(1'b1, 1'b0); press(1'b1, 1'b0); press(1'b1, 1'b0);
    l = load_cnt;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({mode_state, set_hour, set_min, set_sec, hold} !== {2'd0, 8'h12, 8'h00, 8'h00, 1'b0} || load_cnt != l) begin
      errors++;
      $display("FAIL reset_mid_edit got st=%0d %h:%h:%h hold=%b loads=%0d exp st=0 12:00:00 hold=0 loads=%0d",
               mode_state, set_hour, set_min, set_sec, hold, load_cnt - l, 0);
    end
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        cur_hour = 8'($urandom); cur_min = 8'($urandom); cur_sec = 8'($urandom);
      end else begin
        cur_hour = ref_inc(8'h23, 23); cur_min = 8'h00; cur_sec = 8'h00;
        r = $urandom_range(0, 23); cur_hour = {4'(r / 10), 4'(r % 10)};
        r = $urandom_range(0, 59); cur_min  = {4'(r / 10), 4'(r % 10)};
        r = $urandom_range(0, 59); cur_sec  = {4'(r / 10), 4'(r % 10)};
      end
      r = $urandom_range(0, 9);
      if (r < 4)      press(1'b1, 1'b0);
      else if (r < 9) press(1'b0, 1'b1);
      else            press(1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if ({mode_state, set_hour, set_min, set_sec, hold} !== {mstate, mh, mm, ms, (mstate != 2'd0)}) begin
        errors++;
        $display("FAIL random[%0d] got st=%0d %h:%h:%h hold=%b exp st=%0d %h:%h:%h hold=%b",
                 n, mode_state, set_hour, set_min, set_sec, hold, mstate, mh, mm, ms, (mstate != 2'd0));
      end
      checks++;
      if (load_cnt != exp_loads) begin
        errors++; $display("FAIL random_loads[%0d] got %0d exp %0d", n, load_cnt, exp_loads);
      end
    end
  endtask

  task automatic test_timeout();
    int l;
    bit back;
    goto_run();
    cur_hour = 8'h11; cur_min = 8'h11; cur_sec = 8'h11;
    press(1'b1, 1'b0);
    l = load_cnt;
`ifdef SET_TIMEOUT_EN
    back = 1'b0;
    for (int n = 0; n < 120 && !back; n++) begin
      @(negedge clk);
      if (mode_state === 2'd0) back = 1'b1;
    end
    mstate = 2'd0;
    checks++;
    if (!back || load_cnt != l || hold !== 1'b0 || {set_hour, set_min, set_sec} !== {mh, mm, ms}) begin
      errors++;
      $display("FAIL timeout got back=%b loads=%0d hold=%b %h:%h:%h exp back=1 loads=0 hold=0 %h:%h:%h",
               back, load_cnt - l, hold, set_hour, set_min, set_sec, mh, mm, ms);
    end
`else
    back = 1'b0;
    for (int n = 0; n < 3 * TO; n++) begin
      @(negedge clk);
      if (mode_state !== 2'd1) back = 1'b1;
    end
    checks++;
    if (back || load_cnt != l) begin
      errors++; $display("FAIL no_timeout got left_set=%b loads=%0d exp left_set=0 loads=0", back, load_cnt - l);
    end
    goto_run();
`endif
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_edit_sequence();
    test_blink();
    test_same_cycle();
    test_reset_mid_edit();
    test_random();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
